req_gnt_responder: RTL

- Slave (responder) end of the req/gnt/data handshake; the master drives req and data, and this block drives gnt.
- Accepts 8-bit beats into an internal FIFO and presents them downstream on a valid/ready stream.
- Enforces a per-burst beat limit with a holdoff gap, for fairness to other initiators.
- Sits between the bus-side interface (slave view) and the consuming datapath.

---
 rtl/req_gnt_pkg.sv | 13 +
 rtl/resp_fifo.sv | 42 ++++
 rtl/req_gnt_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/req_gnt_pkg.sv
// Shared types and defaults for the req/gnt responder slice.
// Used by req_gnt_responder and its bench.
package req_gnt_pkg;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLDOFF = 2'd2
    } resp_state_t;

    typedef logic [DATA_W-1:0] beat_t;
endpackage

// File: rtl/resp_fifo.sv
// Synchronous first-word-fall-through FIFO: dout always shows the head entry,
// so a beat written in cycle N is visible in cycle N+1.
module resp_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Pointers are exactly log2(DEPTH) wide and wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
endmodule

// File: rtl/req_gnt_responder.sv
// Responder end of a req/gnt beat handshake feeding a valid/ready stream,
// with a per-burst beat limit and holdoff. Optional stats: REQ_GNT_RESP_STATS_EN.
module req_gnt_responder #(
    parameter int DEPTH       = 8,
    parameter int DATA_W      = req_gnt_pkg::DATA_W,
    parameter int MAX_BURST   = 4,
    parameter int HOLDOFF_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [DATA_W-1:0]      data,
    output logic                   gnt,
    output logic                   m_valid,
    output logic [DATA_W-1:0]      m_data,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] count,
`ifdef REQ_GNT_RESP_STATS_EN
    output logic [15:0]            beat_total,
    output logic [15:0]            full_stall,
`endif
    output logic [1:0]             state_dbg
);
    import req_gnt_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int HW = $clog2(HOLDOFF_CYC + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYC);

    resp_state_t   state, state_next;
    logic [BW-1:0] burst_cnt, burst_next;
    logic [HW-1:0] holdoff_cnt, holdoff_next;
    logic [CW-1:0] count_next;
    logic          push, pop, empty, gnt_next;

    // Handshake: a beat moves on req&&gnt upstream and m_valid&&m_ready downstream.
    assign push       = req && gnt;
    assign pop        = m_valid && m_ready;
    assign m_valid    = !empty;
    assign count_next = count + CW'(push) - CW'(pop);
    assign state_dbg  = state;

    resp_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data),
        .dout  (m_data),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            holdoff_cnt <= '0;
            gnt         <= 1'b0;
        end else begin
            state       <= state_next;
            burst_cnt   <= burst_next;
            holdoff_cnt <= holdoff_next;
            gnt         <= gnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        burst_next   = burst_cnt;
        holdoff_next = holdoff_cnt;
        case (state)
            IDLE: begin
                if (req) state_next = GRANT;
            end
            GRANT: begin
                if (push) begin
                    if (burst_cnt == LAST_BEAT) begin
                        state_next   = HOLDOFF;
                        burst_next   = '0;
                        holdoff_next = HOLD_LOAD;
                    end else begin
                        burst_next = burst_cnt + 1'b1;
                    end
                end else if (!req) begin
                    state_next = IDLE;
                    burst_next = '0;
                end
            end
            HOLDOFF: begin
                // Leaving on the last holdoff cycle lets gnt rise right after it.
                if (holdoff_cnt <= HW'(1)) begin
                    state_next   = req ? GRANT : IDLE;
                    holdoff_next = '0;
                end else begin
                    holdoff_next = holdoff_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Granting only when the next-cycle occupancy has room makes overflow impossible.
    assign gnt_next = (state_next == GRANT) && (count_next < DEPTH_C);

`ifdef REQ_GNT_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_total <= '0;
            full_stall <= '0;
        end else begin
            if (push && beat_total != 16'hFFFF)
                beat_total <= beat_total + 16'd1;
            if (req && count == DEPTH_C && full_stall != 16'hFFFF)
                full_stall <= full_stall + 16'd1;
        end
    end
`endif
endmodule
